// File: rtl/clkdiv_pkg.sv
// Shared defaults and constants for the programmable clock divider.
//   DEF_CNT_W : default width of each channel's period/high-time counter
//   DEF_N_CH  : default number of divider channels
//   MIN_PER   : smallest period a channel will run with
package clkdiv_pkg;

  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_N_CH  = 2;
  localparam int unsigned MIN_PER   = 2;

endpackage

// File: rtl/clkdiv_ch.sv
// One programmable divider channel: period counter, registered clkout/tick,
// and an active/pending configuration pair that swaps on period boundaries.
//   clk        : divider input clock (rising edge)
//   rst        : asynchronous active-high reset
//   en         : run enable
//   sync_start : forces the counter to 0 and applies pending config
//   cfg_load   : captures div_val/hi_val into the pending pair
//   div_val    : period in clk cycles
//   hi_val     : high time in clk cycles
//   clkout     : divided clock (registered)
//   tick       : one-cycle pulse at each period start (registered)
//   cfg_err    : active period is below MIN_PER
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_start,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic [CNT_W-1:0] hi_val,
  output logic             clkout,
  output logic             tick,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] MIN_PER_W = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] pend_per_q, pend_per_d;
  logic [CNT_W-1:0] pend_hi_q, pend_hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] hi_eff;
  logic             per_ok;
  logic             wrap;
  logic             apply;

  always_comb begin
    per_ok = (per_q >= MIN_PER_W);
    hi_eff = (hi_q < per_q) ? hi_q : per_q;
    wrap   = en && per_ok && (cnt_q == per_q - ONE);
    // An invalid active config keeps the channel idle, so swapping it in
    // immediately is glitch-free and lets a fresh load start the channel.
    apply  = pend_vld_q && (wrap || sync_start || !en || !per_ok);

    per_d      = per_q;
    hi_d       = hi_q;
    pend_per_d = pend_per_q;
    pend_hi_d  = pend_hi_q;
    pend_vld_d = pend_vld_q;

    // Apply uses the pending pair as it stood before this cycle; a load in
    // the same cycle becomes the next pending pair.
    if (apply) begin
      per_d      = pend_per_q;
      hi_d       = pend_hi_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_load) begin
      pend_per_d = div_val;
      pend_hi_d  = hi_val;
      pend_vld_d = 1'b1;
    end

    if (!en || sync_start || !per_ok || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    clkout_d = en && per_ok && (cnt_q < hi_eff);
    tick_d   = en && per_ok && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q      <= '0;
      hi_q       <= '0;
      pend_per_q <= '0;
      pend_hi_q  <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      per_q      <= per_d;
      hi_q       <= hi_d;
      pend_per_q <= pend_per_d;
      pend_hi_q  <= pend_hi_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
    end
  end

  assign clkout  = clkout_q;
  assign tick    = tick_q;
  assign cfg_err = ~per_ok;

endmodule

// File: rtl/prog_clkdiv.sv
// Multi-channel programmable clock divider. Each channel divides clkin by its
// own period with its own high time; sync_start phase-aligns all channels.
//   clkin      : single clock, rising edge
//   cnt_clr    : asynchronous active-high reset
//   ch_en      : per-channel run enable
//   div_val    : per-channel period, channel k in [k*CNT_W +: CNT_W]
//   hi_val     : per-channel high time, same packing
//   cfg_load   : per-channel strobe capturing div_val/hi_val as pending
//   sync_start : strobe zeroing every channel counter
//   clkout     : per-channel divided clock
//   tick       : per-channel period-start pulse
//   cfg_err    : per-channel invalid-period flag
module prog_clkdiv
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned N_CH  = DEF_N_CH
) (
  input  logic                  clkin,
  input  logic                  cnt_clr,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH*CNT_W-1:0] div_val,
  input  logic [N_CH*CNT_W-1:0] hi_val,
  input  logic [N_CH-1:0]       cfg_load,
  input  logic                  sync_start,
  output logic [N_CH-1:0]       clkout,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       cfg_err
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clkdiv_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clkin),
      .rst        (cnt_clr),
      .en         (ch_en[k]),
      .sync_start (sync_start),
      .cfg_load   (cfg_load[k]),
      .div_val    (div_val[k*CNT_W +: CNT_W]),
      .hi_val     (hi_val[k*CNT_W +: CNT_W]),
      .clkout     (clkout[k]),
      .tick       (tick[k]),
      .cfg_err    (cfg_err[k])
    );
  end

endmodule

// File: tb/tb_prog_clkdiv.sv
module tb_prog_clkdiv;

  logic        clkin = 1'b0;
  logic        cnt_clr;
  logic [1:0]  ch_en;
  logic [31:0] div_val;
  logic [31:0] hi_val;
  logic [1:0]  cfg_load;
  logic        sync_start;
  logic [1:0]  clkout;
  logic [1:0]  tick;
  logic [1:0]  cfg_err;

  int nvec = 0;
  int nerr = 0;

  prog_clkdiv #(
    .CNT_W (16),
    .N_CH  (2)
  ) dut (
    .clkin      (clkin),
    .cnt_clr    (cnt_clr),
    .ch_en      (ch_en),
    .div_val    (div_val),
    .hi_val     (hi_val),
    .cfg_load   (cfg_load),
    .sync_start (sync_start),
    .clkout     (clkout),
    .tick       (tick),
    .cfg_err    (cfg_err)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] dv;
    logic [15:0] hv;
    logic        ck;
    logic        tk;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int en, input int ld, input int dv, input int hv,
                     input int ck, input int tk, input int er);
    vec_t v;
    v.en = (en != 0);
    v.ld = (ld != 0);
    v.dv = dv[15:0];
    v.hv = hv[15:0];
    v.ck = (ck != 0);
    v.tk = (tk != 0);
    v.er = (er != 0);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int found;
    int hi_cnt;
    int first_low;
    int tick_extra;
    int idle_bad;

    // ch0 only, ch1 disabled: {en, load, div, hi, clkout, tick, cfg_err}
    add(1,1,5,2, 0,0,1);   // capture 5/2 while idle
    add(1,0,0,0, 0,0,0);   // applied (active invalid)
    add(1,0,0,0, 1,1,0);   // cnt0
    add(1,0,0,0, 1,0,0);
    add(1,1,9,1, 0,0,0);   // load at cnt=2
    add(1,1,8,4, 0,0,0);   // overwrite pending
    add(1,0,0,0, 0,0,0);   // wrap of 5-period, apply 8/4
    add(1,0,0,0, 1,1,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 1,1,0);   // second 8-period
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,1,4,1, 0,0,0);   // load on wrap cycle: not applied now
    add(1,0,0,0, 1,1,0);   // still 8-period
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);   // wrap, apply 4/1
    add(1,0,0,0, 1,1,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 1,1,0);
    add(1,1,4,0, 0,0,0);   // hi=0
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,1,0);   // constant low, tick
    add(1,1,4,7, 0,0,0);   // hi > per
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 1,1,0);   // constant high
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,1,0);
    add(1,1,1,0, 1,0,0);   // div=1
    add(1,0,0,0, 1,0,0);
    add(1,0,0,0, 1,0,1);   // wrap applies div=1 -> error
    add(1,0,0,0, 0,0,1);
    add(1,0,0,0, 0,0,1);
    add(1,1,4,2, 0,0,1);   // recover
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 1,1,0);

    // reset state
    cnt_clr    = 1'b1;
    ch_en      = '0;
    cfg_load   = '0;
    sync_start = 1'b0;
    div_val    = '0;
    hi_val     = '0;
    repeat (2) cyc();
    chk("rst_clkout", {30'd0, clkout}, 32'd0);
    chk("rst_tick", {30'd0, tick}, 32'd0);
    chk("rst_cfg_err", {30'd0, cfg_err}, 32'd3);
    #1 cnt_clr = 1'b0;

    // table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      ch_en         = {1'b0, tbl[i].en};
      cfg_load      = {1'b0, tbl[i].ld};
      div_val[15:0] = tbl[i].dv;
      hi_val[15:0]  = tbl[i].hv;
      cyc();
      chk($sformatf("vec%0d_clkout", i), {30'd0, clkout}, {30'd0, 1'b0, tbl[i].ck});
      chk($sformatf("vec%0d_tick", i), {30'd0, tick}, {30'd0, 1'b0, tbl[i].tk});
      chk($sformatf("vec%0d_cfg_err", i), {30'd0, cfg_err}, {30'd0, 1'b1, tbl[i].er});
    end
    cfg_load = '0;

    // enable drop for 3 cycles mid-period (ch0 at cnt=1, per 4, hi 2)
    ch_en = 2'b00;
    cyc();
    chk("drop_clkout", {30'd0, clkout}, 32'd0);
    chk("drop_tick", {30'd0, tick}, 32'd0);
    cyc();
    cyc();
    ch_en = 2'b01;
    cyc();
    chk("reen_clkout", {30'd0, clkout}, 32'd1);
    chk("reen_tick", {30'd0, tick}, 32'd1);
    cyc();
    chk("reen_cnt1_clkout", {30'd0, clkout}, 32'd1);
    cyc();
    chk("reen_cnt2_clkout", {30'd0, clkout}, 32'd0);
    cyc();
    cyc();
    chk("reen_next_tick", {30'd0, tick}, 32'd1);

    // sync_start across two channels with skewed phase
    ch_en    = 2'b00;
    div_val  = {16'd9, 16'd6};
    hi_val   = {16'd4, 16'd3};
    cfg_load = 2'b11;
    cyc();
    cfg_load = 2'b00;
    cyc();
    chk("sync_cfg_err", {30'd0, cfg_err}, 32'd0);
    ch_en = 2'b01;
    cyc();
    cyc();
    ch_en = 2'b11;
    cyc();
    chk("skew_tick", {30'd0, tick}, 32'd2);
    cyc();
    sync_start = 1'b1;
    cyc();
    sync_start = 1'b0;
    chk("sync_edge_tick", {30'd0, tick}, 32'd0);
    chk("sync_edge_clkout", {30'd0, clkout}, 32'd2);
    cyc();
    chk("sync_tick_both", {30'd0, tick}, 32'd3);
    chk("sync_clkout_both", {30'd0, clkout}, 32'd3);

    // long period 1000/500 on ch0
    ch_en          = 2'b00;
    div_val[15:0]  = 16'd1000;
    hi_val[15:0]   = 16'd500;
    cfg_load       = 2'b01;
    cyc();
    cfg_load = 2'b00;
    cyc();
    ch_en = 2'b01;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cyc();
      if (tick[0]) found = 1;
    end
    chk("long_first_tick", found, 1);
    hi_cnt     = clkout[0] ? 1 : 0;
    first_low  = -1;
    tick_extra = 0;
    for (int j = 1; j < 1000; j++) begin
      cyc();
      if (clkout[0]) hi_cnt++;
      else if (first_low < 0) first_low = j;
      if (tick[0]) tick_extra++;
    end
    cyc();
    chk("long_period_tick", {31'd0, tick[0]}, 32'd1);
    chk("long_high_cycles", hi_cnt, 500);
    chk("long_first_low", first_low, 500);
    chk("long_extra_ticks", tick_extra, 0);
    chk("long_cfg_err", {31'd0, cfg_err[0]}, 32'd0);
    chk("long_pre_rst_clkout", {31'd0, clkout[0]}, 32'd1);

    // asynchronous reset mid-high phase
    #2 cnt_clr = 1'b1;
    #1;
    chk("async_rst_clkout", {30'd0, clkout}, 32'd0);
    chk("async_rst_tick", {30'd0, tick}, 32'd0);
    chk("async_rst_cfg_err", {30'd0, cfg_err}, 32'd3);
    cyc();
    cyc();
    #1 cnt_clr = 1'b0;
    ch_en = 2'b11;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (clkout != 2'b00 || tick != 2'b00) idle_bad++;
    end
    chk("post_rst_idle", idle_bad, 0);
    chk("post_rst_cfg_err", {30'd0, cfg_err}, 32'd3);
    div_val[15:0] = 16'd4;
    hi_val[15:0]  = 16'd2;
    cfg_load      = 2'b01;
    cyc();
    cfg_load = 2'b00;
    chk("post_rst_load_err", {30'd0, cfg_err}, 32'd3);
    cyc();
    chk("post_rst_apply_err", {30'd0, cfg_err}, 32'd2);
    chk("post_rst_apply_clkout", {30'd0, clkout}, 32'd0);
    cyc();
    chk("post_rst_run_clkout", {30'd0, clkout}, 32'd1);
    chk("post_rst_run_tick", {30'd0, tick}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
